// File: rtl/gtx_1000x_reset_ctrl_if.sv
// Control/status bundle between the GTX reset sequencer and the 1000BASE-X wrapper/PCS.
// master = sequencer side (drives GTX resets and link status), slave = wrapper/PCS side.
interface gtx_1000x_reset_ctrl_if #(
  parameter int RETRY_W = 4
);
  logic               soft_reset_i;
  logic               plllkdet_i;
  logic               dcm_locked_i;
  logic               resetdone_i;
  logic               rxbuferr_i;
  logic               txbuferr_i;
  logic               gtreset_o;
  logic               pmareset_o;
  logic               txreset_o;
  logic               rxreset_o;
  logic               link_ready_o;
  logic [2:0]         state_o;
  logic [RETRY_W-1:0] retry_cnt_o;

  modport master (
    input  soft_reset_i, plllkdet_i, dcm_locked_i, resetdone_i, rxbuferr_i, txbuferr_i,
    output gtreset_o, pmareset_o, txreset_o, rxreset_o, link_ready_o, state_o, retry_cnt_o
  );

  modport slave (
    output soft_reset_i, plllkdet_i, dcm_locked_i, resetdone_i, rxbuferr_i, txbuferr_i,
    input  gtreset_o, pmareset_o, txreset_o, rxreset_o, link_ready_o, state_o, retry_cnt_o
  );
endinterface

// File: rtl/gtx_1000x_reset_ctrl.sv
// GTX 1000BASE-X reset/initialisation sequencer with lock/done timeouts and buffer-fault recovery.
// Status inputs pass a 2-flop synchroniser (2 clk to decision); outputs are registered with the state.
module gtx_1000x_reset_ctrl #(
  parameter int GTRESET_CYCLES   = 16,
  parameter int PLL_TIMEOUT      = 65536,
  parameter int USR_RESET_CYCLES = 8,
  parameter int DONE_TIMEOUT     = 16384,
  parameter int RXREC_CYCLES     = 8,
  parameter int CNT_W            = 17,
  parameter int RETRY_W          = 4
) (
  input logic                   clk,
  input logic                   resetn,
  gtx_1000x_reset_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    GT_RESET   = 3'd1,
    WAIT_PLL   = 3'd2,
    WAIT_DCM   = 3'd3,
    USR_RESET  = 3'd4,
    WAIT_DONE  = 3'd5,
    READY      = 3'd6,
    RX_RECOVER = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0]   GT_LAST   = CNT_W'(GTRESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PLL_LAST  = CNT_W'(PLL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   USR_LAST  = CNT_W'(USR_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   RXR_LAST  = CNT_W'(RXREC_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  logic [4:0]         meta;
  logic [4:0]         sync;
  logic               pll, dcm, done, rxerr, txerr;
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   timer;
  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_inc;
  logic               entry;
  logic               gtreset, txreset, rxreset, link_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {bus.plllkdet_i, bus.dcm_locked_i, bus.resetdone_i, bus.rxbuferr_i, bus.txbuferr_i};
      sync <= meta;
    end
  end

  assign {pll, dcm, done, rxerr, txerr} = sync;

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    case (state)
      GT_RESET:   if (timer == GT_LAST) state_nxt = WAIT_PLL;
      WAIT_PLL: begin
        if (pll) begin
          state_nxt = WAIT_DCM;
        end else if (timer == PLL_LAST) begin
          state_nxt = GT_RESET;
          retry_inc = 1'b1;
        end
      end
      WAIT_DCM: begin
        // Losing PLL lock here is a restart, not a timeout, so it is not counted.
        if (!pll) begin
          state_nxt = GT_RESET;
        end else if (dcm) begin
          state_nxt = USR_RESET;
        end else if (timer == PLL_LAST) begin
          state_nxt = GT_RESET;
          retry_inc = 1'b1;
        end
      end
      USR_RESET:  if (timer == USR_LAST) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (done) begin
          state_nxt = READY;
        end else if (timer == DONE_LAST) begin
          state_nxt = GT_RESET;
          retry_inc = 1'b1;
        end
      end
      READY: begin
        if (!pll || !dcm)  state_nxt = GT_RESET;
        else if (txerr)    state_nxt = USR_RESET;
        else if (rxerr)    state_nxt = RX_RECOVER;
      end
      RX_RECOVER: begin
        if (!pll || !dcm)          state_nxt = GT_RESET;
        else if (timer == RXR_LAST) state_nxt = WAIT_DONE;
      end
      default:    state_nxt = GT_RESET;
    endcase
    if (bus.soft_reset_i) begin
      state_nxt = GT_RESET;
      retry_inc = 1'b0;
    end
  end

  // A soft reset while already in GT_RESET still counts as a fresh entry.
  assign entry = bus.soft_reset_i || (state_nxt != state);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= GT_RESET;
      timer      <= '0;
      retry_cnt  <= '0;
      gtreset    <= 1'b1;
      txreset    <= 1'b1;
      rxreset    <= 1'b1;
      link_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= entry ? '0 : timer + CNT_W'(1);
      if (retry_inc && retry_cnt != RETRY_MAX) retry_cnt <= retry_cnt + RETRY_W'(1);
      gtreset    <= (state_nxt == GT_RESET);
      txreset    <= state_nxt inside {GT_RESET, WAIT_PLL, WAIT_DCM, USR_RESET};
      rxreset    <= state_nxt inside {GT_RESET, WAIT_PLL, WAIT_DCM, USR_RESET, RX_RECOVER};
      link_ready <= (state_nxt == READY);
    end
  end

  assign bus.gtreset_o    = gtreset;
  assign bus.pmareset_o   = gtreset;
  assign bus.txreset_o    = txreset;
  assign bus.rxreset_o    = rxreset;
  assign bus.link_ready_o = link_ready;
  assign bus.state_o      = state;
  assign bus.retry_cnt_o  = retry_cnt;

endmodule

// File: tb/tb_gtx_1000x_reset_ctrl.sv
// Bench for gtx_1000x_reset_ctrl: directed scenarios plus random stimulus against a
// phase/deadline reference model of the bring-up rules.
module tb_gtx_1000x_reset_ctrl;
  localparam int GTRESET_CYCLES   = 16;
  localparam int PLL_TIMEOUT      = 100;
  localparam int USR_RESET_CYCLES = 8;
  localparam int DONE_TIMEOUT     = 200;
  localparam int RXREC_CYCLES     = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  gtx_1000x_reset_ctrl_if #(.RETRY_W(4)) bus ();

  gtx_1000x_reset_ctrl #(
    .GTRESET_CYCLES(GTRESET_CYCLES), .PLL_TIMEOUT(PLL_TIMEOUT),
    .USR_RESET_CYCLES(USR_RESET_CYCLES), .DONE_TIMEOUT(DONE_TIMEOUT),
    .RXREC_CYCLES(RXREC_CYCLES), .CNT_W(17), .RETRY_W(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, cycle the phase began, restart count.
  int         m_s, m_r, m_entry, cyc_no;
  logic [4:0] q_in[$];
  bit gt_tab  [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
  bit tx_tab  [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  bit rx_tab  [8] = '{0, 1, 1, 1, 1, 0, 0, 1};
  bit rdy_tab [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

  task automatic model_reset();
    m_s = 1; m_r = 0; m_entry = 0; cyc_no = 0;
    q_in = '{5'b0, 5'b0};
  endtask

  task automatic model_step();
    logic [4:0] v;
    bit p, d, dn, rxe, txe, inc;
    int n, age;
    v = q_in.pop_front();
    q_in.push_back({bus.plllkdet_i, bus.dcm_locked_i, bus.resetdone_i, bus.rxbuferr_i, bus.txbuferr_i});
    {p, d, dn, rxe, txe} = v;
    age = cyc_no - m_entry;
    n = m_s; inc = 0;
    case (m_s)
      1: if (age == GTRESET_CYCLES - 1) n = 2;
      2: if (p) n = 3; else if (age == PLL_TIMEOUT - 1) begin n = 1; inc = 1; end
      3: if (!p) n = 1; else if (d) n = 4; else if (age == PLL_TIMEOUT - 1) begin n = 1; inc = 1; end
      4: if (age == USR_RESET_CYCLES - 1) n = 5;
      5: if (dn) n = 6; else if (age == DONE_TIMEOUT - 1) begin n = 1; inc = 1; end
      6: if (!p || !d) n = 1; else if (txe) n = 4; else if (rxe) n = 7;
      7: if (!p || !d) n = 1; else if (age == RXREC_CYCLES - 1) n = 5;
      default: n = 1;
    endcase
    if (bus.soft_reset_i) begin n = 1; inc = 0; end
    if (n != m_s || bus.soft_reset_i) m_entry = cyc_no + 1;
    if (inc && m_r < 15) m_r = m_r + 1;
    m_s = n;
    cyc_no = cyc_no + 1;
  endtask

  function automatic logic [11:0] exp_vec();
    return {gt_tab[m_s], gt_tab[m_s], tx_tab[m_s], rx_tab[m_s], rdy_tab[m_s], 3'(m_s), 4'(m_r)};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus.gtreset_o, bus.pmareset_o, bus.txreset_o, bus.rxreset_o, bus.link_ready_o,
            bus.state_o, bus.retry_cnt_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (resetn) model_step();
    @(negedge clk);
  endtask

  task automatic set_inputs(input bit p, input bit d, input bit dn);
    bus.plllkdet_i = p; bus.dcm_locked_i = d; bus.resetdone_i = dn;
    bus.rxbuferr_i = 0; bus.txbuferr_i = 0; bus.soft_reset_i = 0;
  endtask

  task automatic test_reset();
    set_inputs(0, 0, 0);
    resetn = 0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (dut_vec() !== 12'b1111_0_001_0000) begin
      miscompares++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec(), 12'b1111_0_001_0000);
    end
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL reset_model got=%b exp=%b", dut_vec(), exp_vec());
    end
    resetn = 1;
  endtask

  task automatic test_nominal();
    int gt_hi, tx_usr, tx_fall, last;
    int seq[$];
    int exp_seq[6] = '{1, 2, 3, 4, 5, 6};
    gt_hi = bus.gtreset_o ? 1 : 0;
    tx_usr = 0; tx_fall = -1; last = 1;
    seq.push_back(1);
    for (int i = 0; i < 120; i++) begin
      set_inputs(i >= 40, i >= 60, (tx_fall >= 0) && (i >= tx_fall + 10));
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL nominal_c%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (bus.gtreset_o) gt_hi++;
      if (bus.state_o == 3'd4 && bus.txreset_o && bus.rxreset_o) tx_usr++;
      if (int'(bus.state_o) != last) begin last = int'(bus.state_o); seq.push_back(last); end
      if (tx_fall < 0 && !bus.txreset_o) tx_fall = i;
    end
    vectors++;
    if (gt_hi != 16) begin miscompares++; $display("FAIL nominal_gtreset_len got=%0d exp=16", gt_hi); end
    vectors++;
    if (tx_usr != 8) begin miscompares++; $display("FAIL nominal_usr_len got=%0d exp=8", tx_usr); end
    vectors++;
    if (seq.size() != 6) begin
      miscompares++; $display("FAIL nominal_seq_len got=%0d exp=6", seq.size());
    end else begin
      for (int k = 0; k < 6; k++)
        if (seq[k] != exp_seq[k]) begin
          miscompares++; $display("FAIL nominal_seq[%0d] got=%0d exp=%0d", k, seq[k], exp_seq[k]);
        end
    end
    vectors++;
    if (bus.link_ready_o !== 1'b1 || bus.retry_cnt_o !== 4'd0) begin
      miscompares++;
      $display("FAIL nominal_ready got=%b/%0d exp=1/0", bus.link_ready_o, bus.retry_cnt_o);
    end
  endtask

  task automatic bring_up_checked(input string tag);
    set_inputs(1, 1, 1);
    bus.soft_reset_i = 1;
    tick();
    bus.soft_reset_i = 0;
    for (int i = 0; i < 200 && m_s != 6; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL %s_bringup_c%0d got=%b exp=%b", tag, i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock_loss_soft();
    logic [3:0] r0;
    bring_up_checked("lockloss");
    r0 = bus.retry_cnt_o;
    bus.dcm_locked_i = 0;
    repeat (3) tick();
    vectors++;
    if (bus.state_o !== 3'd1 || bus.link_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL lockloss_gtreset got=%0d/%b exp=1/0", bus.state_o, bus.link_ready_o);
    end
    bus.dcm_locked_i = 1;
    for (int i = 0; i < 200 && bus.state_o != 3'd6; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL lockloss_c%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (bus.state_o !== 3'd6 || bus.retry_cnt_o !== r0) begin
      miscompares++;
      $display("FAIL lockloss_resequence got=%0d/%0d exp=6/%0d", bus.state_o, bus.retry_cnt_o, r0);
    end
    // Soft reset while waiting for RESETDONE.
    set_inputs(1, 1, 0);
    bus.soft_reset_i = 1;
    tick();
    bus.soft_reset_i = 0;
    for (int i = 0; i < 100 && m_s != 5; i++) tick();
    vectors++;
    if (bus.state_o !== 3'd5) begin miscompares++; $display("FAIL soft_pre got=%0d exp=5", bus.state_o); end
    bus.soft_reset_i = 1;
    tick();
    bus.soft_reset_i = 0;
    vectors++;
    if (bus.state_o !== 3'd1 || bus.gtreset_o !== 1'b1) begin
      miscompares++; $display("FAIL soft_reset got=%0d/%b exp=1/1", bus.state_o, bus.gtreset_o);
    end
  endtask

  task automatic test_pll_timeout();
    int run, first_run, first_retry;
    bit wrapped;
    logic [3:0] prev;
    set_inputs(0, 0, 0);
    bus.soft_reset_i = 1;
    tick();
    bus.soft_reset_i = 0;
    run = 0; first_run = -1; first_retry = -1; wrapped = 0; prev = bus.retry_cnt_o;
    for (int i = 0; i < 2100; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL plltimeout_c%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (bus.state_o == 3'd2) run++;
      else if (run > 0 && first_run < 0) begin first_run = run; first_retry = bus.retry_cnt_o; end
      if (bus.retry_cnt_o < prev) wrapped = 1;
      prev = bus.retry_cnt_o;
    end
    vectors++;
    if (first_run != PLL_TIMEOUT || first_retry != 1) begin
      miscompares++;
      $display("FAIL plltimeout_first got=%0d/%0d exp=%0d/1", first_run, first_retry, PLL_TIMEOUT);
    end
    vectors++;
    if (bus.retry_cnt_o !== 4'd15 || wrapped) begin
      miscompares++; $display("FAIL plltimeout_sat got=%0d wrap=%0d exp=15 wrap=0", bus.retry_cnt_o, wrapped);
    end
  endtask

  task automatic test_rx_fault();
    int first7, rxcnt, txbad;
    bit saw_done;
    bring_up_checked("rxfault");
    bus.rxbuferr_i = 1;
    tick();
    bus.rxbuferr_i = 0;
    first7 = -1; rxcnt = 0; txbad = 0; saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL rxfault_c%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (bus.state_o == 3'd7) begin
        if (first7 < 0) first7 = i + 2;
        if (bus.rxreset_o) rxcnt++;
        if (bus.txreset_o || bus.link_ready_o) txbad++;
      end
      if (first7 >= 0 && bus.state_o == 3'd5) saw_done = 1;
    end
    vectors++;
    if (first7 < 0 || first7 > 3) begin miscompares++; $display("FAIL rxfault_enter got=%0d exp<=3", first7); end
    vectors++;
    if (rxcnt != 8 || txbad != 0) begin
      miscompares++; $display("FAIL rxfault_pulse got=%0d/%0d exp=8/0", rxcnt, txbad);
    end
    vectors++;
    if (!saw_done || bus.state_o !== 3'd6) begin
      miscompares++; $display("FAIL rxfault_recover got=%0d/%0d exp=1/6", saw_done, bus.state_o);
    end
  endtask

  task automatic test_simul_faults();
    bring_up_checked("simul");
    bus.txbuferr_i = 1; bus.rxbuferr_i = 1;
    tick();
    bus.txbuferr_i = 0; bus.rxbuferr_i = 0;
    repeat (2) tick();
    vectors++;
    if (bus.state_o !== 3'd4 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL simul_txrx got=%0d exp=4", bus.state_o);
    end
    bring_up_checked("simul2");
    bus.txbuferr_i = 1; bus.rxbuferr_i = 1; bus.dcm_locked_i = 0;
    tick();
    bus.txbuferr_i = 0; bus.rxbuferr_i = 0;
    repeat (2) tick();
    vectors++;
    if (bus.state_o !== 3'd1 || dut_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL simul_dcm got=%0d exp=1", bus.state_o);
    end
    bus.dcm_locked_i = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (bus.plllkdet_i) bus.plllkdet_i = ($urandom_range(0, 399) != 0);
      else                bus.plllkdet_i = ($urandom_range(0, 29) == 0);
      if (bus.dcm_locked_i) bus.dcm_locked_i = ($urandom_range(0, 399) != 0);
      else                  bus.dcm_locked_i = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 24) == 0) bus.resetdone_i = ~bus.resetdone_i;
      bus.rxbuferr_i   = ($urandom_range(0, 59) == 0);
      bus.txbuferr_i   = ($urandom_range(0, 89) == 0);
      bus.soft_reset_i = ($urandom_range(0, 699) == 0);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random_c%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    set_inputs(1, 1, 0);
    bus.soft_reset_i = 1;
    tick();
    bus.soft_reset_i = 0;
    for (int i = 0; i < 100 && m_s != 5; i++) tick();
    vectors++;
    if (bus.state_o !== 3'd5) begin miscompares++; $display("FAIL async_pre got=%0d exp=5", bus.state_o); end
    #2;
    resetn = 0;
    #1;
    vectors++;
    if ({bus.gtreset_o, bus.pmareset_o, bus.txreset_o, bus.rxreset_o} !== 4'b1111) begin
      miscompares++;
      $display("FAIL async_resets got=%b exp=1111", {bus.gtreset_o, bus.pmareset_o, bus.txreset_o, bus.rxreset_o});
    end
    vectors++;
    if (bus.link_ready_o !== 1'b0 || bus.state_o !== 3'd1 || bus.retry_cnt_o !== 4'd0) begin
      miscompares++;
      $display("FAIL async_status got=%b/%0d/%0d exp=0/1/0", bus.link_ready_o, bus.state_o, bus.retry_cnt_o);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    bus.resetdone_i = 1;
    for (int i = 0; i < 80; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL async_rebringup_c%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_soft();
    test_pll_timeout();
    test_rx_fault();
    test_simul_faults();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gtx_1000x_reset_ctrl.md
Name: gtx_1000x_reset_ctrl

Overview:
- Reset/initialisation sequencer for the single-channel 1000BASE-X GTX wrapper of the 1G interface pcore.
- Drives the wrapper's GTRESET, PMARESET, TXRESET_0 and RXRESET_0.
- Watches PLL lock, DCM lock, RESETDONE and the elastic-buffer error flags; retries on timeouts and recovers from buffer faults.
- Presents link_ready_o to the EMAC/PCS side.

Parameters:
- GTRESET_CYCLES, 16: cycles GTRESET/PMARESET are held high per attempt.
- PLL_TIMEOUT, 65536: max cycles waiting for PLL lock or DCM lock.
- USR_RESET_CYCLES, 8: cycles TX/RX reset held after DCM lock.
- DONE_TIMEOUT, 16384: max cycles waiting for RESETDONE.
- RXREC_CYCLES, 8: RXRESET pulse length for RX buffer recovery.
- CNT_W, 17: timer width; must hold the largest of the above.
- RETRY_W, 4: retry counter width.

Ports:
- clk  in  1  free-running control clock, independent of the GTX clocks
- resetn  in  1  asynchronous active-low reset
- soft_reset_i  in  1  synchronous request to restart the full sequence
- plllkdet_i  in  1  PLLLKDET_0 from wrapper (asynchronous)
- dcm_locked_i  in  1  user-clock DCM lock (asynchronous)
- resetdone_i  in  1  RESETDONE_0 (asynchronous)
- rxbuferr_i  in  1  RXBUFERR_0 (asynchronous)
- txbuferr_i  in  1  TXBUFERR_0 (asynchronous)
- gtreset_o  out  1  to GTRESET
- pmareset_o  out  1  to PMARESET
- txreset_o  out  1  to TXRESET_0
- rxreset_o  out  1  to RXRESET_0 (RXBUFRESET is tied to the same net)
- link_ready_o  out  1  high only in READY
- state_o  out  3  current state encoding
- retry_cnt_o  out  RETRY_W  count of timeout-triggered restarts, saturating

Behaviour:
- Reset: asynchronous and active-low; the clock is clk and the reset is resetn.
- While resetn is low:
  - state=GT_RESET(1).
  - gtreset_o, pmareset_o, txreset_o and rxreset_o are all 1.
  - link_ready_o=0, retry_cnt_o=0, timer=0.
- Synchronisers: every *_i except soft_reset_i passes through a 2-flop synchroniser (reset value 0). All decisions use the synchronised values, so input-to-decision latency is 2 clk.
- Timer: cleared to 0 on every state entry; otherwise increments by 1 each cycle. "Expires at N" means the state exits in the cycle the timer equals N-1, giving exactly N cycles in the state.
- Outputs are registered and updated in the same edge as the state register.
- State encodings: GT_RESET=1, WAIT_PLL=2, WAIT_DCM=3, USR_RESET=4, WAIT_DONE=5, READY=6, RX_RECOVER=7. Encoding 0 is unused; an illegal state goes to GT_RESET.
- GT_RESET:
  - gtreset=pmareset=txreset=rxreset=1.
  - Expires at GTRESET_CYCLES, then go to WAIT_PLL.
- WAIT_PLL:
  - gtreset=pmareset=0; tx/rxreset stay 1.
  - pll=1 goes to WAIT_DCM.
  - Timer expiring at PLL_TIMEOUT goes to GT_RESET and increments retry_cnt.
- WAIT_DCM:
  - dcm=1 goes to USR_RESET.
  - Timeout at PLL_TIMEOUT goes to GT_RESET with retry_cnt+1.
  - pll=0 goes to GT_RESET without incrementing retry_cnt.
- USR_RESET:
  - tx/rxreset=1.
  - Expires at USR_RESET_CYCLES, then go to WAIT_DONE.
- WAIT_DONE:
  - tx/rxreset=0.
  - resetdone=1 goes to READY.
  - Timeout at DONE_TIMEOUT goes to GT_RESET with retry_cnt+1.
- READY: link_ready_o=1 and all resets are 0. Exit priority, highest first:
  - pll=0 or dcm=0: go to GT_RESET.
  - txbuferr=1: go to USR_RESET.
  - rxbuferr=1: go to RX_RECOVER.
- RX_RECOVER:
  - rxreset=1 and txreset=0.
  - Expires at RXREC_CYCLES, then go to WAIT_DONE.
  - If pll=0 or dcm=0 in the same cycle, go to GT_RESET instead.
- soft_reset_i=1 in any state forces GT_RESET next cycle and overrides every other transition. retry_cnt is not incremented; retry_cnt is cleared only by resetn.
- retry_cnt saturates at 2^RETRY_W-1 and never wraps. Sequencing keeps retrying indefinitely.
- link_ready_o drops in the same edge that leaves READY.

Test Plan:
- Nominal bring-up: release resetn; pll rises at cycle 40, dcm at cycle 60, resetdone 10 cycles after txreset falls.
  - gtreset_o high for exactly 16 cycles.
  - State sequence 1→2→3→4→5→6.
  - tx/rxreset high for 8 cycles after DCM detection.
  - link_ready_o=1 two cycles after resetdone synchronises.
  - retry_cnt_o=0.
- PLL timeout: hold pll=0 with PLL_TIMEOUT=100.
  - Returns to GT_RESET after 100 cycles in WAIT_PLL.
  - retry_cnt_o increments per attempt and saturates at 15 after 15+ attempts, never wrapping to 0.
- RX buffer fault: pulse rxbuferr 1 cycle while in READY.
  - Within 3 cycles state=7 and link_ready_o=0.
  - rxreset_o high exactly 8 cycles while txreset_o stays 0.
  - Then WAIT_DONE, then READY.
- Simultaneous faults in READY: txbuferr=1 and rxbuferr=1 in the same cycle.
  - Goes to USR_RESET (4), not RX_RECOVER.
  - With dcm also dropping in that cycle, goes to GT_RESET.
- Lock loss and soft reset:
  - Drop dcm in READY: GT_RESET, full resequence, retry_cnt_o unchanged.
  - Assert soft_reset_i in WAIT_DONE: next state GT_RESET.
- Async reset mid-sequence: assert resetn low in WAIT_DONE between clock edges.
  - All four resets go to 1 and link_ready_o to 0 immediately, without a clock edge.
  - retry_cnt_o=0 and state_o=1.
